cache_arbiter: RTL and testbench

Two-to-one physical-memory arbiter between the L1 instruction cache and the L1 data cache of the pipelined LC-3b. It sits downstream of the MEM-stage memory-access control: data-cache misses and write-backs, including both accesses of an LDI/STI, drain through it. Each miss is serialized onto the single line-wide physical memory port. Response and read data are routed back to the requesting cache. A last-grant bit prevents either side from starving the other.

---
 rtl/cache_arbiter_if.sv | 40 ++++
 rtl/cache_arbiter.sv | 102 ++++++++++
 tb/tb_cache_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Signal bundle between the LC-3b L1 caches, physical memory and the arbiter.
// The arbiter uses the slave view; the caches/memory environment uses master.
interface cache_arbiter_if;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic [127:0] icache_pmem_rdata;
  logic         icache_pmem_resp;

  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;

  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    output icache_pmem_rdata, icache_pmem_resp,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_rdata, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output icache_pmem_read, icache_pmem_address,
    input  icache_pmem_rdata, icache_pmem_resp,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_rdata, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-to-one arbiter serializing I-cache fills and D-cache fills/write-backs
// onto the single line-wide physical memory port, alternating under contention.
module cache_arbiter (
  input  logic            clk,
  input  logic            reset,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t       state, state_next;
  grant_t       last_grant;
  logic [15:0]  req_address;
  logic [127:0] req_wdata;
  logic         req_write;
  logic         grant_i, grant_d;
  logic         i_req, d_req;

  assign i_req = bus.icache_pmem_read;
  assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

  // Fill data goes straight through; each cache qualifies it with its own resp.
  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GRANT_I;
      req_address <= '0;
      req_wdata   <= '0;
      req_write   <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        last_grant  <= GRANT_D;
        req_address <= bus.dcache_pmem_address;
        req_wdata   <= bus.dcache_pmem_wdata;
        // A simultaneous read+write is a write-back followed later by the refill.
        req_write   <= bus.dcache_pmem_write;
      end else if (grant_i) begin
        last_grant  <= GRANT_I;
        req_address <= bus.icache_pmem_address;
        req_wdata   <= '0;
        req_write   <= 1'b0;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next           = state;
    grant_i              = 1'b0;
    grant_d              = 1'b0;
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.pmem_address     = '0;
    bus.pmem_wdata       = '0;
    bus.icache_pmem_resp = 1'b0;
    bus.dcache_pmem_resp = 1'b0;

    case (state)
      IDLE: begin
        // D wins ties unless it won last time; pmem_resp here is ignored.
        if (d_req && (!i_req || last_grant == GRANT_I)) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end
      end

      SERVE_I: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = req_address;
        if (bus.pmem_resp) begin
          bus.icache_pmem_resp = 1'b1;
          state_next           = IDLE;
        end
      end

      SERVE_D: begin
        bus.pmem_read    = ~req_write;
        bus.pmem_write   = req_write;
        bus.pmem_address = req_address;
        bus.pmem_wdata   = req_wdata;
        if (bus.pmem_resp) begin
          bus.dcache_pmem_resp = 1'b1;
          state_next           = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs driven and outputs sampled on the
// falling edge, with hand-computed expectations per scenario.
module tb_cache_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [127:0] FILL_DATA = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] WB_DATA   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] ALT_DATA  = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.icache_pmem_read    = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = '0;
    bus.pmem_rdata          = '0;
    bus.pmem_resp           = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] outs;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      outs = {bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp};
      checks++;
      if (outs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got %b exp 0000", i, outs);
      end
      checks++;
      if (bus.pmem_address !== 16'h0000 || bus.pmem_wdata !== 128'h0) begin
        errors++;
        $display("FAIL reset_bus got addr %h wdata %h exp 0", bus.pmem_address, bus.pmem_wdata);
      end
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    outs = {bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp};
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL spurious_resp got %b exp 0000", outs);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    outs = {bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp, bus.dcache_pmem_resp};
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("FAIL after_spurious got %b exp 0000", outs);
    end
  endtask

  task automatic test_icache_read();
    @(negedge clk);
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h1230;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL ird_early got %b exp 0", bus.pmem_read);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.pmem_read, bus.pmem_write} !== 2'b10 || bus.pmem_address !== 16'h1230) begin
        errors++;
        $display("FAIL ird_strobe cycle %0d got rw %b addr %h exp rw 10 addr 1230",
                 i, {bus.pmem_read, bus.pmem_write}, bus.pmem_address);
      end
      checks++;
      if (bus.icache_pmem_resp !== 1'b0) begin
        errors++;
        $display("FAIL ird_resp_early got %b exp 0", bus.icache_pmem_resp);
      end
    end
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = FILL_DATA;
    #1;
    checks++;
    if (bus.icache_pmem_resp !== 1'b1 || bus.dcache_pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL ird_resp got i %b d %b exp i 1 d 0", bus.icache_pmem_resp, bus.dcache_pmem_resp);
    end
    checks++;
    if (bus.icache_pmem_rdata !== FILL_DATA) begin
      errors++;
      $display("FAIL ird_data got %h exp %h", bus.icache_pmem_rdata, FILL_DATA);
    end
    @(negedge clk);
    bus.pmem_resp        = 1'b0;
    bus.icache_pmem_read = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp} !== 3'b000) begin
        errors++;
        $display("FAIL ird_after cycle %0d got %b exp 000", i,
                 {bus.pmem_read, bus.pmem_write, bus.icache_pmem_resp});
      end
      step();
    end
  endtask

  task automatic test_dcache_writeback();
    @(negedge clk);
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 16'h4000;
    bus.dcache_pmem_wdata   = WB_DATA;
    step();
    bus.dcache_pmem_address = 16'h5000;
    bus.dcache_pmem_wdata   = ALT_DATA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.pmem_read, bus.pmem_write} !== 2'b01 || bus.pmem_address !== 16'h4000
          || bus.pmem_wdata !== WB_DATA) begin
        errors++;
        $display("FAIL wb_hold cycle %0d got rw %b addr %h wdata %h exp rw 01 addr 4000 wdata %h",
                 i, {bus.pmem_read, bus.pmem_write}, bus.pmem_address, bus.pmem_wdata, WB_DATA);
      end
      checks++;
      if (bus.dcache_pmem_resp !== 1'b0) begin
        errors++;
        $display("FAIL wb_resp_early got %b exp 0", bus.dcache_pmem_resp);
      end
      @(negedge clk);
    end
    bus.pmem_resp = 1'b1;
    #1;
    checks++;
    if (bus.dcache_pmem_resp !== 1'b1 || bus.icache_pmem_resp !== 1'b0
        || bus.pmem_address !== 16'h4000) begin
      errors++;
      $display("FAIL wb_resp got d %b i %b addr %h exp d 1 i 0 addr 4000",
               bus.dcache_pmem_resp, bus.icache_pmem_resp, bus.pmem_address);
    end
    @(negedge clk);
    bus.pmem_resp         = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    #1;
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.dcache_pmem_resp} !== 3'b000) begin
      errors++;
      $display("FAIL wb_after got %b exp 000", {bus.pmem_read, bus.pmem_write, bus.dcache_pmem_resp});
    end
    step();
  endtask

  task automatic test_contention();
    logic [15:0] exp_addr [3];
    logic        exp_d    [3];
    exp_addr[0] = 16'h2000; exp_d[0] = 1'b1;
    exp_addr[1] = 16'h1000; exp_d[1] = 1'b0;
    exp_addr[2] = 16'h2000; exp_d[2] = 1'b1;
    apply_reset();
    @(negedge clk);
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h1000;
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'h2000;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({bus.pmem_read, bus.pmem_write} !== 2'b10 || bus.pmem_address !== exp_addr[k]) begin
        errors++;
        $display("FAIL arb_grant %0d got rw %b addr %h exp rw 10 addr %h",
                 k, {bus.pmem_read, bus.pmem_write}, bus.pmem_address, exp_addr[k]);
      end
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = ALT_DATA;
      #1;
      checks++;
      if (bus.dcache_pmem_resp !== exp_d[k] || bus.icache_pmem_resp !== ~exp_d[k]) begin
        errors++;
        $display("FAIL arb_resp %0d got d %b i %b exp d %b i %b",
                 k, bus.dcache_pmem_resp, bus.icache_pmem_resp, exp_d[k], ~exp_d[k]);
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (k == 2) begin
        bus.icache_pmem_read = 1'b0;
        bus.dcache_pmem_read = 1'b0;
      end
      #1;
      checks++;
      if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
        errors++;
        $display("FAIL arb_turnaround %0d got %b exp 00", k, {bus.pmem_read, bus.pmem_write});
      end
    end
    step();
  endtask

  task automatic test_read_write_together();
    int resp_count;
    @(negedge clk);
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_address = 16'h3000;
    bus.dcache_pmem_wdata   = WB_DATA;
    step();
    checks++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b01 || bus.pmem_address !== 16'h3000) begin
      errors++;
      $display("FAIL rw_both got rw %b addr %h exp rw 01 addr 3000",
               {bus.pmem_read, bus.pmem_write}, bus.pmem_address);
    end
    resp_count = 0;
    bus.pmem_resp = 1'b1;
    #1;
    if (bus.dcache_pmem_resp === 1'b1) resp_count++;
    @(negedge clk);
    bus.pmem_resp         = 1'b0;
    bus.dcache_pmem_read  = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.dcache_pmem_resp === 1'b1) resp_count++;
      @(negedge clk);
    end
    checks++;
    if (resp_count !== 1) begin
      errors++;
      $display("FAIL rw_resp_count got %0d exp 1", resp_count);
    end
  endtask

  task automatic test_reset_mid_service();
    @(negedge clk);
    bus.dcache_pmem_read    = 1'b1;
    bus.dcache_pmem_address = 16'h6000;
    step();
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h6000) begin
      errors++;
      $display("FAIL rst_mid_pre got rd %b addr %h exp rd 1 addr 6000", bus.pmem_read, bus.pmem_address);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_strobe got %b exp 00", {bus.pmem_read, bus.pmem_write});
    end
    reset                = 1'b0;
    bus.dcache_pmem_read = 1'b0;
    bus.pmem_resp        = 1'b1;
    #1;
    checks++;
    if (bus.dcache_pmem_resp !== 1'b0 || bus.icache_pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_late_resp got d %b i %b exp 0 0", bus.dcache_pmem_resp, bus.icache_pmem_resp);
    end
    @(negedge clk);
    bus.pmem_resp           = 1'b0;
    bus.icache_pmem_read    = 1'b1;
    bus.icache_pmem_address = 16'h7770;
    step();
    checks++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b10 || bus.pmem_address !== 16'h7770) begin
      errors++;
      $display("FAIL rst_mid_fresh got rw %b addr %h exp rw 10 addr 7770",
               {bus.pmem_read, bus.pmem_write}, bus.pmem_address);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = FILL_DATA;
    #1;
    checks++;
    if (bus.icache_pmem_resp !== 1'b1 || bus.icache_pmem_rdata !== FILL_DATA) begin
      errors++;
      $display("FAIL rst_mid_fresh_resp got resp %b data %h exp resp 1 data %h",
               bus.icache_pmem_resp, bus.icache_pmem_rdata, FILL_DATA);
    end
    @(negedge clk);
    bus.pmem_resp        = 1'b0;
    bus.icache_pmem_read = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_icache_read();
    test_dcache_writeback();
    test_contention();
    test_read_write_together();
    test_reset_mid_service();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
